// File: rtl/fmul_round_norm_if.sv
// Operand/result handshake bundle for the multiplier back-end (round and normalise) stage.
// The master drives the upstream operands and the downstream ready; the slave is the stage itself.
interface fmul_round_norm_if #(
    parameter int PROD_W = 48,
    parameter int EXP_W  = 10
);
    logic              valid_i;
    logic              ready_o;
    logic              sign_i;
    logic [EXP_W-1:0]  exp_i;
    logic [PROD_W-1:0] mant_i;
    logic [1:0]        special_i;
    logic              valid_o;
    logic              ready_i;
    logic [31:0]       result_o;
    logic [2:0]        flags_o;

    modport master (
        output valid_i, sign_i, exp_i, mant_i, special_i, ready_i,
        input  ready_o, valid_o, result_o, flags_o
    );

    modport slave (
        input  valid_i, sign_i, exp_i, mant_i, special_i, ready_i,
        output ready_o, valid_o, result_o, flags_o
    );
endinterface

// File: rtl/fmul_round_norm.sv
// binary32 multiplier back-end: normalise (S1), round-to-nearest-even and pack (S2).
// Define FMUL_FTZ_EN to flush tiny results to signed zero instead of gradual underflow.
module fmul_round_norm #(
    parameter int PROD_W = 48,
    parameter int EXP_W  = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fmul_round_norm_if.slave bus
);
    localparam int EW   = EXP_W + 2;
    localparam int SH_W = 6;
    localparam logic signed [EW-1:0] C_ONE = EW'(1);
    localparam logic signed [EW-1:0] C_CAP = EW'(26);

    logic                     w_ready;
    logic                     w_s1Load;
    logic                     w_s2Load;

    logic signed [EW-1:0]     w_expIn;
    logic [SH_W-1:0]          w_lz;
    logic signed [EW-1:0]     w_lzS;
    logic signed [EW-1:0]     w_lshAmt;
    logic signed [EW-1:0]     w_eNorm;
    logic [PROD_W-1:0]        w_mNorm;
    logic                     w_stickyHi;
    logic signed [EW-1:0]     w_rshFull;
    logic [4:0]               w_rsh;
    logic signed [EW-1:0]     w_eFinal;
    logic [PROD_W-1:0]        w_mFinal;
    logic                     w_stickyLo;
    logic [1:0]               w_special;
    logic                     w_unusedBits;

    logic                     r_s1Valid;
    logic                     r_s1Sign;
    logic [EXP_W-1:0]         r_s1Exp;
    logic [23:0]              r_s1Kept;
    logic                     r_s1Guard;
    logic                     r_s1Sticky;
    logic [1:0]               r_s1Special;

    logic                     w_roundUp;
    logic [24:0]              w_sum;
    logic [EXP_W:0]           w_expR;
    logic [23:0]              w_sig;
    logic [EXP_W:0]           w_field;
    logic                     w_inexact;
    logic                     w_tiny;
    logic                     w_ovf;
    logic [31:0]              w_result;
    logic [2:0]               w_flags;

    logic                     r_s2Valid;
    logic [31:0]              r_result;
    logic [2:0]               r_flags;

    assign w_ready     = !r_s1Valid || !r_s2Valid || bus.ready_i;
    assign w_s1Load    = bus.valid_i && w_ready;
    assign w_s2Load    = r_s1Valid && (!r_s2Valid || bus.ready_i);
    assign bus.ready_o  = w_ready;
    assign bus.valid_o  = r_s2Valid;
    assign bus.result_o = r_result;
    assign bus.flags_o  = r_flags;

    assign w_expIn = {{(EW-EXP_W){bus.exp_i[EXP_W-1]}}, bus.exp_i};
    assign w_lzS   = {{(EW-SH_W){1'b0}}, w_lz};

    // Leading zeros below the integer bit (bit 46); 47 when that whole field is clear.
    always_comb begin
        w_lz = SH_W'(47);
        for (int i = 0; i <= PROD_W - 2; i++) begin
            if (bus.mant_i[i]) w_lz = SH_W'(PROD_W - 2 - i);
        end
    end

    always_comb begin
        w_mNorm    = bus.mant_i;
        w_eNorm    = w_expIn;
        w_stickyHi = 1'b0;
        w_lshAmt   = '0;
        if (bus.mant_i[PROD_W-1]) begin
            w_mNorm    = bus.mant_i >> 1;
            w_stickyHi = bus.mant_i[0];
            w_eNorm    = w_expIn + C_ONE;
        end else if (!bus.mant_i[PROD_W-2] && (w_expIn > C_ONE)) begin
            w_lshAmt = (w_lzS < (w_expIn - C_ONE)) ? w_lzS : (w_expIn - C_ONE);
            w_mNorm  = bus.mant_i << w_lshAmt[SH_W-1:0];
            w_eNorm  = w_expIn - w_lshAmt;
        end
    end

    assign w_rshFull = C_ONE - w_eNorm;

    // Denormalise into the subnormal scale; a 26-bit shift already pushes every significant bit into sticky.
    always_comb begin
        w_mFinal   = w_mNorm;
        w_eFinal   = w_eNorm;
        w_stickyLo = 1'b0;
        w_rsh      = '0;
        if (w_eNorm < C_ONE) begin
            w_rsh      = (w_rshFull > C_CAP) ? 5'd26 : w_rshFull[4:0];
            w_mFinal   = w_mNorm >> w_rsh;
            w_stickyLo = |(w_mNorm & ((PROD_W'(1) << w_rsh) - PROD_W'(1)));
            w_eFinal   = '0;
        end
    end

    assign w_special    = ((bus.special_i == 2'b00) && (bus.mant_i == '0)) ? 2'b01 : bus.special_i;
    assign w_unusedBits = ^{w_mFinal[PROD_W-1], w_eFinal[EW-1:EXP_W], w_lshAmt[EW-1:SH_W], w_rshFull[EW-1:5]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1Valid   <= 1'b0;
            r_s1Sign    <= 1'b0;
            r_s1Exp     <= '0;
            r_s1Kept    <= '0;
            r_s1Guard   <= 1'b0;
            r_s1Sticky  <= 1'b0;
            r_s1Special <= 2'b00;
        end else begin
            if (w_s1Load) begin
                r_s1Valid   <= 1'b1;
                r_s1Sign    <= bus.sign_i;
                r_s1Exp     <= w_eFinal[EXP_W-1:0];
                r_s1Kept    <= w_mFinal[PROD_W-2:PROD_W-25];
                r_s1Guard   <= w_mFinal[PROD_W-26];
                r_s1Sticky  <= (|w_mFinal[PROD_W-27:0]) | w_stickyHi | w_stickyLo;
                r_s1Special <= w_special;
            end else if (w_s2Load) begin
                r_s1Valid   <= 1'b0;
            end
        end
    end

    assign w_roundUp = r_s1Guard && (r_s1Sticky || r_s1Kept[0]);
    assign w_sum     = {1'b0, r_s1Kept} + 25'(w_roundUp);
    assign w_expR    = {1'b0, r_s1Exp} + (EXP_W+1)'(w_sum[24]);
    assign w_sig     = w_sum[24] ? w_sum[24:1] : w_sum[23:0];

    // Without the hidden bit the value sits in the subnormal scale (field 0); gaining it from e=0 lands on field 1.
    assign w_field   = !w_sig[23] ? '0 :
                       (w_expR == '0) ? (EXP_W+1)'(1) : w_expR;
    assign w_inexact = r_s1Guard || r_s1Sticky;
    assign w_tiny    = (w_field == '0);
    assign w_ovf     = (w_field >= (EXP_W+1)'(255));

    always_comb begin
        w_result = 32'h0000_0000;
        w_flags  = 3'b000;
        case (r_s1Special)
            2'b11: w_result = 32'h7FC0_0000;
            2'b10: w_result = {r_s1Sign, 8'hFF, 23'd0};
            2'b01: w_result = {r_s1Sign, 31'd0};
            default: begin
                if (w_ovf) begin
                    w_result = {r_s1Sign, 8'hFF, 23'd0};
                    w_flags  = 3'b101;
                end else if (w_tiny) begin
`ifdef FMUL_FTZ_EN
                    w_result = {r_s1Sign, 31'd0};
                    w_flags  = 3'b011;
`else
                    w_result = {r_s1Sign, 8'h00, w_sig[22:0]};
                    w_flags  = {1'b0, w_inexact, w_inexact};
`endif
                end else begin
                    w_result = {r_s1Sign, w_field[7:0], w_sig[22:0]};
                    w_flags  = {2'b00, w_inexact};
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2Valid <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
        end else begin
            if (w_s2Load) begin
                r_s2Valid <= 1'b1;
                r_result  <= w_result;
                r_flags   <= w_flags;
            end else if (bus.ready_i) begin
                r_s2Valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fmul_round_norm.md
Name: fmul_round_norm

Overview:
- Back-end stage of the single-precision multiplier. It sits directly downstream of the mantissa-product stage.
- It takes the raw 48-bit significand product, the pre-normalisation biased exponent, the sign and a special-case code, and produces a packed IEEE-754 binary32 result with exception flags.
- It normalises, handles the subnormal range, rounds to nearest-even, and detects overflow and underflow.
- Two-stage pipeline with a valid/ready handshake on both sides.

Parameters:
- PROD_W, 48, width of the significand product (24x24).
- EXP_W, 10, width of the signed pre-normalisation exponent.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  upstream holds a valid operand set.
- ready_o  out  1  block accepts the operand set this cycle.
- sign_i  in  1  result sign (sign_a XOR sign_b).
- exp_i  in  EXP_W  signed biased exponent, ea+eb-127; subnormal operands contribute exponent 1.
- mant_i  in  PROD_W  significand product; binary point between bits 46 and 45.
- special_i  in  2  00 = normal, 01 = zero, 10 = infinity, 11 = NaN.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  32  packed binary32 result.
- flags_o  out  3  {overflow, underflow, inexact}.

Behaviour:
- Reset: valid_o=0, ready_o=1, result_o=0, flags_o=0, both stage-valid bits cleared.
- Reset asserted mid-operation discards all in-flight data; no output is produced for it.
- Handshake:
  - Transfer in when valid_i && ready_o. Transfer out when valid_o && ready_i.
  - ready_o = !s1_valid || !s2_valid || ready_i (the S1 register is free, or S1 can advance into S2 this cycle).
  - S2 loads when it is empty or being drained.
  - Throughput 1/cycle. Latency 2 cycles from input transfer to valid_o when there is no backpressure.
  - result_o, flags_o and valid_o hold stable while valid_o && !ready_i. Order is preserved and nothing is dropped.
- Stage S1 (normalise), applied to normal inputs:
  - mant_i[47]=1: shift right 1, e = exp_i+1. Bit shifted out goes to sticky.
  - mant_i[47:46]=01: no shift, e = exp_i.
  - Otherwise: lz = leading zeros counted from bit 46. Left shift by min(lz, e-1) when e>1; e is reduced by that amount.
  - mant_i=0 with special_i=00: treated as zero.
  - If e<1 after the steps above: right shift by (1-e), capped at 26; all shifted-out bits OR into sticky; e=0 (subnormal).
  - S1 registers: sign, e (EXP_W), the 24-bit kept field (bits 46:23), guard (bit 22), sticky (OR of bits 21:0 plus shifted-out bits), special code.
- Stage S2 (round and pack):
  - RNE: round up iff guard && (sticky || lsb).
  - Carry out of 24 bits: shift right 1, e+1.
  - Subnormal whose rounding sets bit 23: e becomes 1 through the normal packing, no special case needed.
  - inexact = guard || sticky.
  - Overflow when e >= 255 after rounding: result = {sign, 0xFF, 0}, flags overflow=1, inexact=1.
  - tiny = (e==0 after rounding). underflow = tiny && inexact.
  - Packing: {sign, e[7:0], kept[22:0]}.
- Special codes bypass the arithmetic and produce flags=0:
  - zero gives {sign, 31'b0};
  - infinity gives {sign, 0xFF, 23'b0};
  - NaN gives 0x7FC00000 with the sign ignored.

Optional Feature:
- Macro FMUL_FTZ_EN: flush-to-zero.
- Defined: any result that would be subnormal after rounding (tiny, including exact tiny results) is output as {sign, 31'b0} with underflow=1 and inexact=1.
- Undefined: gradual underflow exactly as described in Behaviour.

Test Plan:
- sign 0, exp_i=127, mant_i=0x900000000000 (1.5x1.5) -> result 0x40100000, flags 000, valid_o exactly 2 cycles after accept.
- exp_i=127, mant_i=0x400000400000 (tie, lsb 0) -> 0x3F800000, flags 001. Same with mant_i=0x400000C00000 (tie, lsb 1) -> 0x3F800002, flags 001.
- exp_i=254, mant_i=0x800000000000 -> 0x7F800000, flags 101. Sign 1 gives 0xFF800000.
- exp_i=0, mant_i=0x400000000000 -> 0x00400000, flags 000. With FMUL_FTZ_EN -> 0x00000000, flags 011.
- special_i=11 with sign 1 -> 0x7FC00000. special_i=01 with sign 1 -> 0x80000000. Both with flags 000.
- Backpressure: ready_i=0 while 4 consecutive inputs are offered -> ready_o drops after 2 accepts; then ready_i=1 -> all 4 results emerge in order, none lost. Asserting rst_i mid-stream -> valid_o=0 on the next edge and nothing in flight is emitted.
